// File: rtl/player_anim_pkg.sv
// Shared types and constants for the player sprite animation sequencer.
package player_anim_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WALK  = 2'd1,
    AIR   = 2'd2,
    DYING = 2'd3
  } anim_state_t;

  localparam logic [1:0] FRM_STAND = 2'd0;
  localparam logic [1:0] FRM_WALKA = 2'd1;
  localparam logic [1:0] FRM_WALKB = 2'd2;
  localparam logic [1:0] FRM_AIR   = 2'd3;

endpackage

// File: rtl/frame_event_detect.sv
// Rising-edge detector on the start-of-frame strobe: one event per frame,
// no matter how many cycles the strobe stays high.
module frame_event_detect (
  input  logic clk,
  input  logic reset,
  input  logic sof,
  output logic frm_ev
);

  logic sof_prev;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) sof_prev <= 1'b0;
    else       sof_prev <= sof;
  end

  assign frm_ev = sof & ~sof_prev;

endmodule

// File: rtl/player_anim_ctrl.sv
// Player sprite sequencer: motion state, facing, walk-cycle phase and death
// blink, advanced once per VGA frame; plus the mirrored bitmap X offset.
module player_anim_ctrl
  import player_anim_pkg::*;
#(
  parameter int FRAMES_PER_STEP = 6,
  parameter int DEATH_FRAMES    = 60,
  parameter int BLINK_PERIOD    = 4,
  parameter int SPRITE_W_BITS   = 5
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        startOfFrame,
  input  logic        moveLeft,
  input  logic        moveRight,
  input  logic        onGround,
  input  logic        playerDied,
  input  logic [10:0] offsetX,
  output logic [1:0]  frameIdx,
  output logic        mirrorX,
  output logic [10:0] bitmapOffsetX,
  output logic        enableDraw,
  output logic [1:0]  animState,
  output logic        deathDone
);

  localparam int STEP_W  = $clog2(FRAMES_PER_STEP);
  localparam int DEATH_W = $clog2(DEATH_FRAMES);
  localparam logic [STEP_W-1:0]  STEP_LAST  = STEP_W'(FRAMES_PER_STEP - 1);
  localparam logic [DEATH_W-1:0] DEATH_LAST = DEATH_W'(DEATH_FRAMES - 1);

  logic frm_ev;

  anim_state_t        state, state_next;
  logic [1:0]         frame_idx, frame_next;
  logic               mirror, mirror_next;
  logic               enable, enable_next;
  logic               done, done_next;
  logic [STEP_W-1:0]  step_cnt, step_next;
  logic [DEATH_W-1:0] death_cnt, death_next;

  logic move_one;
  logic death_last;
  logic blink_edge;

  frame_event_detect u_frame_event_detect (
    .clk    (clk),
    .reset  (reset),
    .sof    (startOfFrame),
    .frm_ev (frm_ev)
  );

  assign move_one   = moveLeft ^ moveRight;
  assign death_last = (death_cnt == DEATH_LAST);
  assign blink_edge = (int'(death_cnt) % BLINK_PERIOD) == (BLINK_PERIOD - 1);

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      frame_idx <= FRM_STAND;
      mirror    <= 1'b0;
      enable    <= 1'b1;
      done      <= 1'b0;
      step_cnt  <= '0;
      death_cnt <= '0;
    end else begin
      state     <= state_next;
      frame_idx <= frame_next;
      mirror    <= mirror_next;
      enable    <= enable_next;
      done      <= done_next;
      step_cnt  <= step_next;
      death_cnt <= death_next;
    end
  end

  // NOTE: every combinational output gets a default first, so no path can infer a latch.
  always_comb begin
    state_next = state;
    if (frm_ev) begin
      case (state)
        DYING: if (death_last) state_next = IDLE;
        default: begin
          if (playerDied)     state_next = DYING;
          else if (!onGround) state_next = AIR;
          else if (move_one)  state_next = WALK;
          else                state_next = IDLE;
        end
      endcase
    end
  end

  always_comb begin
    frame_next  = frame_idx;
    mirror_next = mirror;
    enable_next = enable;
    done_next   = 1'b0;
    step_next   = step_cnt;
    death_next  = death_cnt;

    if (frm_ev) begin
      if (state == DYING) begin
        // Inputs are ignored until the blink sequence runs out.
        if (death_last) begin
          enable_next = 1'b1;
          death_next  = '0;
          frame_next  = FRM_STAND;
          done_next   = 1'b1;
        end else begin
          death_next = death_cnt + 1'b1;
          if (blink_edge) enable_next = ~enable;
        end
      end else begin
        if (moveLeft && !moveRight)      mirror_next = 1'b1;
        else if (moveRight && !moveLeft) mirror_next = 1'b0;

        case (state_next)
          DYING: begin
            death_next = '0;
            step_next  = '0;
          end
          AIR: begin
            frame_next = FRM_AIR;
            step_next  = '0;
          end
          WALK: begin
            if (state != WALK) begin
              frame_next = FRM_WALKA;
              step_next  = '0;
            end else if (step_cnt == STEP_LAST) begin
              frame_next = (frame_idx == FRM_WALKA) ? FRM_WALKB : FRM_WALKA;
              step_next  = '0;
            end else begin
              step_next = step_cnt + 1'b1;
            end
          end
          default: begin
            frame_next = FRM_STAND;
            step_next  = '0;
          end
        endcase
      end
    end
  end

  assign frameIdx   = frame_idx;
  assign mirrorX    = mirror;
  assign enableDraw = enable;
  assign animState  = state;
  assign deathDone  = done;

  // Mirroring flips the X position within one sprite; the sprite index bits stay put.
  assign bitmapOffsetX = mirror
      ? {offsetX[10:SPRITE_W_BITS], ~offsetX[SPRITE_W_BITS-1:0]}
      : offsetX;

endmodule
